// File: rtl/upg_pkg.sv
// Shared definitions for the UART program-load port: state encoding and the
// address/data widths also used by cpu_top for the upg_* wires.
package upg_pkg;

  localparam int unsigned UPG_REGION_BIT = 14;
  localparam int unsigned UPG_ADR_W      = 15;
  localparam int unsigned UPG_DAT_W      = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoadI,
    StLoadD,
    StFlush
  } upg_state_e;

  // Builds a programming-port address from the target region and word index.
  function automatic logic [UPG_ADR_W-1:0] upg_adr(input logic dmem,
                                                  input logic [UPG_REGION_BIT-1:0] idx);
    return {dmem, idx};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = d_i;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/upg_loader_ctrl.sv
// UART program loader: assembles little-endian words from received bytes and
// writes them to program ROM then data memory through the upg_* port.
module upg_loader_ctrl
  import upg_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 16384,
  parameter int unsigned DMEM_WORDS = 16384,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_pg,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 upg_wen_o,
  output logic [UPG_ADR_W-1:0] upg_adr_o,
  output logic [UPG_DAT_W-1:0] upg_dat_o,
  output logic                 upg_done_o,
  output logic                 load_err_o
);

  localparam int unsigned IdxW   = UPG_REGION_BIT;
  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IdxW-1:0]   ImemLast = IdxW'(IMEM_WORDS - 1);
  localparam logic [IdxW-1:0]   DmemLast = (DMEM_WORDS == 0) ? '0 : IdxW'(DMEM_WORDS - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  upg_state_e state_q, state_d;

  logic [1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [UPG_DAT_W-1:0] word_q, word_d;
  logic                 last_q, last_d;
  logic                 wen_q, wen_d;
  logic [UPG_ADR_W-1:0] adr_q, adr_d;
  logic [UPG_DAT_W-1:0] dat_q, dat_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic start_edge;

  sync_edge u_sync_edge (
    .clk_i   (clk),
    .rst_ni  (rst),
    .d_i     (start_pg),
    .pulse_o (start_edge)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    word_d  = word_q;
    last_d  = last_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StLoadI;
          err_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          timer_d = '0;
          last_d  = 1'b0;
          done_d  = 1'b0;
        end
      end

      StLoadI, StLoadD: begin
        if (rx_valid) begin
          timer_d = '0;
          word_d  = {rx_data, word_q[UPG_DAT_W-1:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wen_d  = 1'b1;
            adr_d  = upg_adr(state_q == StLoadD, idx_q);
            dat_d  = word_d;
            last_d = (state_q == StLoadI) ? (idx_q == ImemLast) : (idx_q == DmemLast);
            idx_d  = last_d ? '0 : idx_q + IdxW'(1);
          end
        end else if (timer_q == TimerMax) begin
          // Byte timeout: abandon any partial word and hand the port back.
          state_d = StIdle;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end

        // Region switch waits for the final strobe so it is never cut short.
        if (wen_q && last_q) begin
          last_d = 1'b0;
          if (state_q == StLoadI && DMEM_WORDS != 0) begin
            state_d = StLoadD;
          end else begin
            state_d = StFlush;
          end
        end
      end

      StFlush: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end

      default: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      word_q  <= word_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign load_err_o = err_q;

endmodule

// File: doc/upg_loader_ctrl.md
# upg_loader_ctrl

UART program-load controller for the single-cycle RISC-V core. Accepts a byte stream from the UART receiver after a `start_pg` request, assembles little-endian 32-bit words, and sequences them into program ROM, then data memory, through the `upg_*` programming port shared by `programrom` and `memory`. While loading, it holds `upg_done_o` low so the memories give the port priority over the CPU. It releases the core once the image is written or a byte timeout aborts the load.

## Interface
- `IMEM_WORDS`, 16384: words written to program ROM per load; range 1..16384.
- `DMEM_WORDS`, 16384: words written to data memory per load; range 0..16384.
- `TIMEOUT`, 1000000: maximum idle clk cycles between bytes during a load.
- `clk`  in  1  single system clock; also drives the `upg_clk` path.
- `rst`  in  1  asynchronous, active-low reset.
- `start_pg`  in  1  asynchronous load request; level-held button.
- `rx_valid`  in  1  one-cycle strobe; a received byte is on `rx_data`.
- `rx_data`  in  8  received byte.
- `upg_wen_o`  out  1  one-cycle write strobe to the memories.
- `upg_adr_o`  out  15  bit 14 selects the target (0 = program ROM, 1 = data memory); bits [13:0] are the word index.
- `upg_dat_o`  out  32  assembled word.
- `upg_done_o`  out  1  1 = CPU owns the memories; 0 = load in progress.
- `load_err_o`  out  1  sticky timeout flag.

## Operation
- Reset values: `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=1, `load_err_o`=0. State is IDLE and all counters are 0.
- `start_pg` passes through a 2-flop synchronizer, then rising-edge detection. Only an edge seen in IDLE starts a load.
- States:
  - IDLE: on edge, go to LOAD_I. In the same transition, clear `load_err_o`, byte count, word index, and timer, and drive `upg_done_o`=0.
  - LOAD_I: each `rx_valid` shifts `rx_data` into the word. The first byte goes to bits [7:0] and the fourth to [31:24].
    - On the 4th byte: `upg_wen_o`=1 next cycle with `upg_adr_o`={0, idx}; idx then increments.
    - After write number IMEM_WORDS: go to LOAD_D with idx=0, or to FLUSH if DMEM_WORDS=0.
  - LOAD_D: same byte assembly with `upg_adr_o`={1, idx}. After write number DMEM_WORDS, go to FLUSH.
  - FLUSH: one cycle, then IDLE with `upg_done_o`=1.
- Timeout, in LOAD_I and LOAD_D only:
  - The timer clears on load start and on every accepted byte; otherwise it increments each cycle.
  - If the timer equals TIMEOUT-1 and `rx_valid`=0, the next state is IDLE with `load_err_o`=1 and `upg_done_o`=1.
  - No write is issued for a partial word.
- `rx_valid` in IDLE or FLUSH is ignored. `start_pg` edges outside IDLE are ignored.

## Timing
- `start_pg` rising before clk edge k means `upg_done_o` is 0 after edge k+3 (2-flop synchronizer, then the state update).
- Write latency: 4th byte strobe sampled at edge n means `upg_wen_o`=1 for exactly the cycle after edge n. `upg_adr_o` and `upg_dat_o` are stable in that cycle and hold until the next write.
- Final write at cycle after edge n: FLUSH at edge n+1, then `upg_done_o`=1 after edge n+2. The CPU never sees the port while a write is pending.
- `rx_valid` on the same cycle the timer reaches TIMEOUT-1: the byte is accepted, the timer clears, and there is no error.
- Back-to-back `rx_valid` every cycle is supported. Byte accept and write strobe overlap without loss.
- `rst` low at any time returns all outputs to reset values asynchronously. The partial word and address are discarded, and the next load restarts at ROM word 0.
- Widths:
  - idx is 14 bits and never wraps, because the parameter ranges bound it.
  - Byte counter is 2 bits.
  - Timer is $clog2(TIMEOUT) bits, saturating at the compare.

## Structure
- Shared package `upg_pkg`:
  - state encoding (IDLE, LOAD_I, LOAD_D, FLUSH);
  - `UPG_REGION_BIT`=14;
  - `UPG_ADR_W`=15 and `UPG_DAT_W`=32. These are reused by `cpu_top` for the `upg_*` wires.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rising-edge pulse, with async active-low reset to 0.

## Test plan
Benches run with IMEM_WORDS=2, DMEM_WORDS=1, TIMEOUT=20.
- **Reset:** hold `rst`=0 → `upg_done_o`=1 and `upg_wen_o`/`upg_adr_o`/`upg_dat_o`/`load_err_o`=0.
- **Full load:**
  - Stimulus: `start_pg` pulse, then bytes 78 56 34 12, EF BE AD DE, 01 02 03 04.
  - Required writes: three single-cycle strobes, {0x0000, 0x12345678}, {0x0001, 0xDEADBEEF}, {0x4000, 0x04030201}.
  - Release: `upg_done_o`=1 two cycles after the last strobe.
- **Timeout:** start, bytes AA BB, then 20 idle cycles → `load_err_o`=1 and `upg_done_o`=1, no strobe. A new start clears `load_err_o`.
- **Ignored inputs:** `rx_valid` with 0x55 in IDLE → no state change. A second `start_pg` edge mid-load → load continues unaffected.
- **Reset mid-load:** `rst` low after 6 bytes → reset values. A restarted load writes its first word at 0x0000.
- **Timeout race:** `rx_valid` on the cycle the timer is at 19 → byte accepted, no error, load completes normally.
